// File: rtl/aluv_pipe_if.sv
// Operation/result bus of the pipelined vector ALU: request side with valid/ready,
// result side with valid/ready and per-lane compare flags.
interface aluv_pipe_if #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LANES         = 6,
    parameter int unsigned SELECTOR_SIZE = 3
);
    logic                               in_valid;
    logic                               in_ready;
    logic [SELECTOR_SIZE-1:0]           selector;
    logic                               sat_en;
    logic [LANES-1:0]                   lane_mask;
    logic [LANES-1:0][DATA_WIDTH-1:0]   operand1;
    logic [LANES-1:0][DATA_WIDTH-1:0]   operand2;
    logic                               out_valid;
    logic                               out_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0]   out;
    logic [LANES-1:0]                   outComparison;

    modport master (
        output in_valid, selector, sat_en, lane_mask, operand1, operand2, out_ready,
        input  in_ready, out_valid, out, outComparison
    );

    modport slave (
        input  in_valid, selector, sat_en, lane_mask, operand1, operand2, out_ready,
        output in_ready, out_valid, out, outComparison
    );
endinterface

// File: rtl/aluv_pipe.sv
// Two-stage pipelined vector ALU: S1 captures the operation, S2 holds the computed
// per-lane results; both stages stall together under output backpressure.
module aluv_pipe #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned LANES         = 6,
    parameter int unsigned SELECTOR_SIZE = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    aluv_pipe_if.slave bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned WW = 2 * DATA_WIDTH;

    localparam logic [SELECTOR_SIZE-1:0] OP_ADD = SELECTOR_SIZE'(3'd0);
    localparam logic [SELECTOR_SIZE-1:0] OP_SUB = SELECTOR_SIZE'(3'd1);
    localparam logic [SELECTOR_SIZE-1:0] OP_MUL = SELECTOR_SIZE'(3'd2);
    localparam logic [SELECTOR_SIZE-1:0] OP_AND = SELECTOR_SIZE'(3'd3);
    localparam logic [SELECTOR_SIZE-1:0] OP_OR  = SELECTOR_SIZE'(3'd4);
    localparam logic [SELECTOR_SIZE-1:0] OP_XOR = SELECTOR_SIZE'(3'd5);
    localparam logic [SELECTOR_SIZE-1:0] OP_SLT = SELECTOR_SIZE'(3'd6);
    localparam logic [SELECTOR_SIZE-1:0] OP_EQ  = SELECTOR_SIZE'(3'd7);

    // Signed clamp bounds, sign-extended to the double-width arithmetic domain
    localparam logic [WW-1:0] SAT_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [WW-1:0] SAT_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    typedef logic [LANES-1:0][W-1:0] lanes_t;

    logic                     advance_c;
    logic                     s1_valid;
    logic [SELECTOR_SIZE-1:0] s1_sel;
    logic                     s1_sat;
    logic [LANES-1:0]         s1_mask;
    lanes_t                   s1_a;
    lanes_t                   s1_b;
    logic                     s2_valid;
    lanes_t                   s2_out;
    logic [LANES-1:0]         s2_cmp;
    lanes_t                   res_c;
    logic [LANES-1:0]         cmp_c;

    logic [WW-1:0] wa, wb, sum, diff, prod;
    logic [W-1:0]  r;
    logic          flag;

    function automatic logic [W-1:0] clamp(input logic [WW-1:0] v);
        if ($signed(v) > $signed(SAT_MAX)) return SAT_MAX[W-1:0];
        if ($signed(v) < $signed(SAT_MIN)) return SAT_MIN[W-1:0];
        return v[W-1:0];
    endfunction

    assign advance_c         = !s2_valid || bus.out_ready;
    assign bus.in_ready      = advance_c;
    assign bus.out_valid     = s2_valid;
    assign bus.out           = s2_out;
    assign bus.outComparison = s2_cmp;

    // S1: capture the presented operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sel   <= '0;
            s1_sat   <= 1'b0;
            s1_mask  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (advance_c) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sel  <= bus.selector;
                s1_sat  <= bus.sat_en;
                s1_mask <= bus.lane_mask;
                s1_a    <= bus.operand1;
                s1_b    <= bus.operand2;
            end
        end
    end

    // Per-lane compute; one sign-extended double-width multiplier serves wrap and sat
    always_comb begin
        res_c = '0;
        cmp_c = '0;
        wa    = '0;
        wb    = '0;
        sum   = '0;
        diff  = '0;
        prod  = '0;
        r     = '0;
        flag  = 1'b0;
        for (int i = 0; i < int'(LANES); i++) begin
            wa   = {{W{s1_a[i][W-1]}}, s1_a[i]};
            wb   = {{W{s1_b[i][W-1]}}, s1_b[i]};
            sum  = wa + wb;
            diff = wa - wb;
            prod = wa * wb;
            r    = '0;
            flag = 1'b0;
            case (s1_sel)
                OP_ADD:  r = s1_sat ? clamp(sum)  : sum[W-1:0];
                OP_SUB:  r = s1_sat ? clamp(diff) : diff[W-1:0];
                OP_MUL:  r = s1_sat ? clamp(prod) : prod[W-1:0];
                OP_AND:  r = s1_a[i] & s1_b[i];
                OP_OR:   r = s1_a[i] | s1_b[i];
                OP_XOR:  r = s1_a[i] ^ s1_b[i];
                OP_SLT: begin
                    flag = $signed(s1_a[i]) < $signed(s1_b[i]);
                    r    = {{(W-1){1'b0}}, flag};
                end
                OP_EQ: begin
                    flag = s1_a[i] == s1_b[i];
                    r    = {{(W-1){1'b0}}, flag};
                end
                default: r = '0;
            endcase
            if (!s1_mask[i]) begin
                r    = s1_a[i];
                flag = 1'b0;
            end
            res_c[i] = r;
            cmp_c[i] = flag;
        end
    end

    // S2: result register; data only moves on a valid op so out reads 0 until the first result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_cmp   <= '0;
        end else if (advance_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_out <= res_c;
                s2_cmp <= cmp_c;
            end
        end
    end
endmodule

// File: tb/tb_aluv_pipe.sv
// Directed self-checking bench for aluv_pipe: arithmetic/saturation, compare and mask,
// pipelining with bubbles, backpressure and asynchronous reset.
module tb_aluv_pipe;
    localparam int unsigned DW = 8;
    localparam int unsigned LN = 6;
    localparam int unsigned SS = 3;
    localparam int NA = 16;

    typedef logic [LN-1:0][DW-1:0] lanes_t;

    // sel, sat, a, b, expected (same value on all lanes)
    localparam logic [2:0] AR_SEL [NA] = '{3'd1, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2,
                                           3'd2, 3'd0, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    localparam logic       AR_SAT [NA] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam logic [7:0] AR_A   [NA] = '{8'h04, 8'h04, 8'h7F, 8'h7F, 8'h80, 8'h80, 8'h1F, 8'h1F,
                                           8'hFF, 8'h80, 8'h80, 8'h80, 8'hF0, 8'hF0, 8'hF0, 8'hFF};
    localparam logic [7:0] AR_B   [NA] = '{8'h06, 8'h06, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0E, 8'h0E,
                                           8'h0F, 8'h80, 8'h80, 8'h7F, 8'h3C, 8'h3C, 8'h3C, 8'h0F};
    localparam logic [7:0] AR_EXP [NA] = '{8'hFE, 8'hFE, 8'h80, 8'h7F, 8'h80, 8'h7F, 8'hB2, 8'h7F,
                                           8'hF1, 8'h80, 8'h7F, 8'h80, 8'h30, 8'hFC, 8'hCC, 8'h0E};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    aluv_pipe_if #(.DATA_WIDTH(DW), .LANES(LN), .SELECTOR_SIZE(SS)) bus ();

    aluv_pipe #(.DATA_WIDTH(DW), .LANES(LN), .SELECTOR_SIZE(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Issue one op into an idle pipe and collect its result (lat = edges until out_valid)
    task automatic run_op(input logic [2:0] sel, input logic sat, input logic [5:0] mask,
                          input lanes_t a, input lanes_t b,
                          output lanes_t res, output logic [5:0] cmp, output int lat);
        bus.selector  = sel;
        bus.sat_en    = sat;
        bus.lane_mask = mask;
        bus.operand1  = a;
        bus.operand2  = b;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.out;
        cmp = bus.outComparison;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++;
        if (bus.out !== '0) begin n_err++; $display("FAIL reset_out got %h want 0", bus.out); end
        n_cmp++;
        if (bus.outComparison !== '0) begin n_err++; $display("FAIL reset_cmp got %b want 0", bus.outComparison); end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0) begin
            n_err++; $display("FAIL post_reset_idle got v=%b out=%h want v=0 out=0", bus.out_valid, bus.out);
        end
    endtask

    task automatic test_add_wrap();
        lanes_t res;
        logic [5:0] cmp;
        int lat;
        run_op(3'd0, 1'b0, 6'b111111,
               {8'h05, 8'hFF, 8'h05, 8'h02, 8'h04, 8'h01},
               {8'h08, 8'h0F, 8'h06, 8'h04, 8'h05, 8'h01}, res, cmp, lat);
        n_cmp++;
        if (res !== {8'h0D, 8'h0E, 8'h0B, 8'h06, 8'h09, 8'h02}) begin
            n_err++; $display("FAIL add_wrap_out got %h want 0d0e0b060902", res);
        end
        n_cmp++;
        if (cmp !== 6'b0) begin n_err++; $display("FAIL add_wrap_cmp got %b want 000000", cmp); end
        n_cmp++;
        if (lat != 2) begin n_err++; $display("FAIL add_wrap_latency got %0d want 2", lat); end
    endtask

    task automatic test_arith_sat_mul();
        lanes_t res;
        logic [5:0] cmp;
        int lat;
        for (int i = 0; i < NA; i++) begin
            run_op(AR_SEL[i], AR_SAT[i], 6'b111111, {6{AR_A[i]}}, {6{AR_B[i]}}, res, cmp, lat);
            n_cmp++;
            if (res !== {6{AR_EXP[i]}} || cmp !== 6'b0) begin
                n_err++;
                $display("FAIL arith[%0d] sel=%0d sat=%b a=%h b=%h got out=%h cmp=%b want lanes=%h cmp=000000",
                         i, AR_SEL[i], AR_SAT[i], AR_A[i], AR_B[i], res, cmp, AR_EXP[i]);
            end
        end
    endtask

    task automatic test_compare_mask();
        lanes_t res;
        logic [5:0] cmp;
        int lat;
        run_op(3'd6, 1'b0, 6'b111110,
               {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01, 8'hFF},
               {8'h01, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h01}, res, cmp, lat);
        n_cmp++;
        if (res !== {8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'hFF} || cmp !== 6'b111100) begin
            n_err++; $display("FAIL slt_mask got out=%h cmp=%b want out=0101010100ff cmp=111100", res, cmp);
        end
        run_op(3'd7, 1'b1, 6'b111111, {6{8'h3C}}, {6{8'h3C}}, res, cmp, lat);
        n_cmp++;
        if (res !== {6{8'h01}} || cmp !== 6'b111111) begin
            n_err++; $display("FAIL eq_all got out=%h cmp=%b want out=010101010101 cmp=111111", res, cmp);
        end
        run_op(3'd7, 1'b0, 6'b011111, {6{8'h3C}},
               {8'h3C, 8'h3C, 8'h3C, 8'h3D, 8'h3C, 8'h3C}, res, cmp, lat);
        n_cmp++;
        if (res !== {8'h3C, 8'h01, 8'h01, 8'h00, 8'h01, 8'h01} || cmp !== 6'b011011) begin
            n_err++; $display("FAIL eq_mask got out=%h cmp=%b want out=3c0101000101 cmp=011011", res, cmp);
        end
        run_op(3'd3, 1'b0, 6'b010101, {6{8'hF0}}, {6{8'h3C}}, res, cmp, lat);
        n_cmp++;
        if (res !== {8'hF0, 8'h30, 8'hF0, 8'h30, 8'hF0, 8'h30} || cmp !== 6'b0) begin
            n_err++; $display("FAIL and_mask got out=%h cmp=%b want out=f030f030f030 cmp=000000", res, cmp);
        end
    endtask

    // Ops in cycles 0,1,3 with a bubble in cycle 2; results must keep the same spacing
    task automatic test_back_to_back();
        logic exp_v;
        bus.out_ready = 1'b1;
        bus.selector  = 3'd0;
        bus.sat_en    = 1'b0;
        bus.lane_mask = 6'b111111;
        bus.operand2  = {6{8'h20}};
        for (int c = 0; c < 9; c++) begin
            bus.in_valid = (c < 4 && c != 2);
            bus.operand1 = {6{8'(c + 1)}};
            #1;
            exp_v = (c >= 2 && c <= 5 && c != 4);
            n_cmp++;
            if (bus.out_valid !== exp_v || (exp_v && bus.out !== {6{8'(c - 1 + 32)}})) begin
                n_err++;
                $display("FAIL b2b cycle %0d got v=%b out=%h want v=%b lanes=%h",
                         c, bus.out_valid, bus.out, exp_v, 8'(c - 1 + 32));
            end
            if (bus.in_ready !== 1'b1) begin
                n_cmp++; n_err++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, bus.in_ready);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int nrx = 0;
        logic [7:0] rx [8];
        int rx_cyc [8];
        logic saw_stall = 1'b0;
        logic prev_hold = 1'b0;
        lanes_t prev_out = '0;
        bus.selector  = 3'd0;
        bus.sat_en    = 1'b0;
        bus.lane_mask = 6'b111111;
        bus.operand2  = {6{8'h10}};
        for (int c = 0; c < 24; c++) begin
            bus.out_ready = (c < 2 || c >= 8);
            bus.in_valid  = (idx < 4);
            bus.operand1  = {6{8'(idx + 1)}};
            #1;
            if (prev_hold) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out !== prev_out) begin
                    n_err++; $display("FAIL bp_hold cycle %0d got v=%b out=%h want v=1 out=%h",
                                      c, bus.out_valid, bus.out, prev_out);
                end
            end
            if (bus.in_ready === 1'b0) saw_stall = 1'b1;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (nrx < 8) begin
                    rx[nrx]     = bus.out[0];
                    rx_cyc[nrx] = c;
                end
                nrx++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) idx++;
            prev_hold = (bus.out_valid === 1'b1) && !bus.out_ready;
            prev_out  = bus.out;
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (saw_stall !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_drop got 0 want 1"); end
        n_cmp++;
        if (nrx != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", nrx); end
        for (int k = 0; k < 4 && k < nrx; k++) begin
            n_cmp++;
            if (rx[k] !== 8'(k + 8'h11)) begin
                n_err++; $display("FAIL bp_order[%0d] got %h want %h", k, rx[k], 8'(k + 8'h11));
            end
        end
        if (nrx >= 4) begin
            n_cmp++;
            if (rx_cyc[0] != 8 || rx_cyc[1] != 9 || rx_cyc[2] != 10 || rx_cyc[3] != 11) begin
                n_err++; $display("FAIL bp_drain_cycles got %0d,%0d,%0d,%0d want 8,9,10,11",
                                  rx_cyc[0], rx_cyc[1], rx_cyc[2], rx_cyc[3]);
            end
        end
    endtask

    task automatic test_reset_midflight();
        lanes_t res;
        logic [5:0] cmp;
        int lat;
        int stray = 0;
        bus.out_ready = 1'b1;
        bus.sat_en    = 1'b0;
        bus.lane_mask = 6'b111111;
        bus.selector  = 3'd7;
        bus.operand1  = {6{8'h55}};
        bus.operand2  = {6{8'h55}};
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.selector  = 3'd0;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.outComparison !== 6'b111111) begin
            n_err++; $display("FAIL rst_mid_preload got v=%b cmp=%b want v=1 cmp=111111",
                              bus.out_valid, bus.outComparison);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.out !== '0 || bus.outComparison !== '0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_async got v=%b out=%h cmp=%b rdy=%b want v=0 out=0 cmp=0 rdy=1",
                              bus.out_valid, bus.out, bus.outComparison, bus.in_ready);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) stray++;
        end
        n_cmp++;
        if (stray != 0) begin n_err++; $display("FAIL rst_mid_stray got %0d valid cycles want 0", stray); end
        run_op(3'd0, 1'b0, 6'b111111, {6{8'h10}}, {6{8'h05}}, res, cmp, lat);
        n_cmp++;
        if (res !== {6{8'h15}} || lat != 2) begin
            n_err++; $display("FAIL rst_mid_new_op got out=%h lat=%0d want lanes=15 lat=2", res, lat);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.selector  = '0;
        bus.sat_en    = 1'b0;
        bus.lane_mask = '1;
        bus.operand1  = '0;
        bus.operand2  = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_add_wrap();
        test_arith_sat_mul();
        test_compare_mask();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want bench completion");
        $fatal(1, "watchdog expired");
    end
endmodule
